// File: rtl/latch_bist_pkg.sv
// Shared types and pattern generation for the latch bank BIST.
package latch_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_CLOSE,
    ST_DISTURB,
    ST_NEXT,
    ST_DONE
  } bist_state_e;

  // Pattern k: 0 = all-zero, 1 = all-one, k >= 2 = walking one at bit k-2.
  function automatic logic pattern_bit(input int unsigned k, input int unsigned bit_idx);
    if (k == 1) return 1'b1;
    if (k >= 2) return (bit_idx == k - 2);
    return 1'b0;
  endfunction

endpackage

// File: rtl/latch_cell.sv
// Single transparent latch whose open level is chosen per channel by pol_i.
module latch_cell (
  input  logic en_i,
  input  logic pol_i,
  input  logic d_i,
  output logic q_o
);

  always_latch begin
    if (en_i == pol_i) q_o <= d_i;
  end

endmodule

// File: rtl/latch_bank_bist.sv
// Latch bank with manual pin access and a transparency/hold BIST sequencer.
// Optional LATCH_BIST_INJECT_EN adds inj_mask_i, XORed into q before each check.
//
// state   | meaning
// IDLE    | latches follow man_en/man_d, waiting for bist_start
// OPEN    | latches transparent on the current pattern, transparency check on last cycle
// CLOSE   | latches closed, data still equals the pattern
// DISTURB | latches closed, data inverted, hold check on last cycle
// NEXT    | latches closed, advance pattern or finish
// DONE    | one-cycle completion pulse
module latch_bank_bist
  import latch_bist_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  pol_i,
  input  logic [N_CH-1:0]  man_en_i,
  input  logic [N_CH-1:0]  man_d_i,
  input  logic             bist_start_i,
`ifdef LATCH_BIST_INJECT_EN
  input  logic [N_CH-1:0]  inj_mask_i,
`endif
  output logic [N_CH-1:0]  q_o,
  output logic             bist_busy_o,
  output logic             bist_done_o,
  output logic             bist_pass_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int STEP_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam int PAT_W    = $clog2(N_CH + 2);

  localparam logic [STEP_W-1:0] SETTLE_LOAD = STEP_W'(SETTLE_CYC - 1);
  localparam logic [STEP_W-1:0] HOLD_LOAD   = STEP_W'(HOLD_CYC - 1);
  localparam logic [PAT_W-1:0]  LAST_PAT    = PAT_W'(N_CH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  bist_state_e      state_q, state_d;
  logic [PAT_W-1:0] pat_idx_q, pat_idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;

  logic [N_CH-1:0]  pat;
  logic [N_CH-1:0]  lat_en;
  logic [N_CH-1:0]  lat_d;
  logic [N_CH-1:0]  inj_mask;
  logic             chk_en;
  logic             chk_fail;

`ifdef LATCH_BIST_INJECT_EN
  assign inj_mask = inj_mask_i;
`else
  assign inj_mask = '0;
`endif

  always_comb begin
    pat = '0;
    for (int i = 0; i < N_CH; i++) begin
      pat[i] = pattern_bit(32'(pat_idx_q), i);
    end
  end

  // Enable/data steering; kept apart from the FSM so q never loops back into it combinationally.
  always_comb begin
    lat_en = ~pol_i;
    lat_d  = pat;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: begin
          lat_en = man_en_i;
          lat_d  = man_d_i;
        end
        ST_OPEN:    lat_en = pol_i;
        ST_DISTURB: lat_d  = ~pat;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lat
    latch_cell u_cell (
      .en_i  (lat_en[g]),
      .pol_i (pol_i[g]),
      .d_i   (lat_d[g]),
      .q_o   (q_o[g])
    );
  end

  assign chk_fail = ((q_o ^ inj_mask) != pat);

  always_comb begin
    state_d   = state_q;
    pat_idx_d = pat_idx_q;
    step_d    = step_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    chk_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bist_start_i) begin
          state_d   = ST_OPEN;
          pat_idx_d = '0;
          step_d    = SETTLE_LOAD;
          err_cnt_d = '0;
          pass_d    = 1'b0;
        end
      end
      ST_OPEN: begin
        if (step_q == '0) begin
          chk_en  = 1'b1;
          state_d = ST_CLOSE;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      ST_CLOSE: begin
        state_d = ST_DISTURB;
        step_d  = HOLD_LOAD;
      end
      ST_DISTURB: begin
        if (step_q == '0) begin
          chk_en  = 1'b1;
          state_d = ST_NEXT;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      ST_NEXT: begin
        if (pat_idx_q == LAST_PAT) begin
          state_d = ST_DONE;
          pass_d  = (err_cnt_q == '0);
        end else begin
          state_d   = ST_OPEN;
          pat_idx_d = pat_idx_q + 1'b1;
          step_d    = SETTLE_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (chk_en && chk_fail && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pat_idx_q <= '0;
      step_q    <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_idx_q <= pat_idx_d;
      step_q    <= step_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign bist_busy_o = (state_q != ST_IDLE);
  assign bist_done_o = (state_q == ST_DONE);
  assign bist_pass_o = pass_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_latch_bank_bist.sv
// Randomized bench for latch_bank_bist against a pattern-level reference model.
module tb_latch_bank_bist;

  localparam int N_CH    = 8;
  localparam int SETTLE  = 2;
  localparam int HOLD    = 4;
  localparam int CNT_W   = 8;
  localparam int PAT_CYC = SETTLE + HOLD + 2;
  localparam int N_PAT   = N_CH + 2;
  localparam int RUN_CYC = N_PAT * PAT_CYC;
  localparam int N_CHK   = 2 * N_PAT;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pol, man_en, man_d, inj_mask;
  logic       bist_start;
  logic [7:0] q;
  logic       bist_busy, bist_done, bist_pass;
  logic [7:0] err_cnt;
  logic [7:0] model_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_bank_bist #(.N_CH(N_CH), .SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD), .CNT_W(CNT_W)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pol_i        (pol),
    .man_en_i     (man_en),
    .man_d_i      (man_d),
    .bist_start_i (bist_start),
`ifdef LATCH_BIST_INJECT_EN
    .inj_mask_i   (inj_mask),
`endif
    .q_o          (q),
    .bist_busy_o  (bist_busy),
    .bist_done_o  (bist_done),
    .bist_pass_o  (bist_pass),
    .err_cnt_o    (err_cnt)
  );

`ifdef LATCH_BIST_INJECT_EN
  logic [7:0] q_sat;
  logic       busy_sat, done_sat, pass_sat;
  logic [3:0] err_sat;

  latch_bank_bist #(.N_CH(N_CH), .SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD), .CNT_W(4)) u_dut_sat (
    .clk_i        (clk),
    .rst_i        (rst),
    .pol_i        (pol),
    .man_en_i     (man_en),
    .man_d_i      (man_d),
    .bist_start_i (bist_start),
    .inj_mask_i   (inj_mask),
    .q_o          (q_sat),
    .bist_busy_o  (busy_sat),
    .bist_done_o  (done_sat),
    .bist_pass_o  (pass_sat),
    .err_cnt_o    (err_sat)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pat(input int k);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hFF;
    return 8'(1 << (k - 2));
  endfunction

  function automatic int exp_errs(input logic [7:0] mask, input int cnt_w);
    int cap;
    cap = (1 << cnt_w) - 1;
    if (mask == 8'h00) return 0;
    return (N_CHK > cap) ? cap : N_CHK;
  endfunction

  // Drive manual pins on a negedge and update the model for transparent channels.
  task automatic set_man(input logic [7:0] p, input logic [7:0] e, input logic [7:0] d, input logic r);
    rst    = r;
    pol    = p;
    man_en = e;
    man_d  = d;
    if (!r) begin
      for (int i = 0; i < 8; i++) if (e[i] == p[i]) model_q[i] = d[i];
    end
    @(negedge clk);
  endtask

  task automatic run_bist(input bit hold_start, output int busy_cyc, output int done_cyc,
                          output int done_cnt, output int q_bad);
    int cyc;
    busy_cyc   = 0;
    done_cyc   = 0;
    done_cnt   = 0;
    q_bad      = 0;
    bist_start = 1'b1;
    @(negedge clk);
    if (!hold_start) bist_start = 1'b0;
    cyc = 1;
    while (bist_busy && cyc < 300) begin
      busy_cyc++;
      if (bist_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc <= RUN_CYC && q !== model_pat((cyc - 1) / PAT_CYC)) q_bad++;
      if (cyc < RUN_CYC - 2) begin
        man_en = 8'($urandom);
        man_d  = 8'($urandom);
        if (!hold_start) bist_start = ($urandom_range(0, 7) == 0);
      end else begin
        man_en     = ~pol;
        bist_start = hold_start;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int busy_cyc, done_cyc, done_cnt, q_bad, cnt, done_seen;
    logic [7:0] p, e, d;
    bit r;

    rst = 1'b1; pol = 8'hFF; man_en = 8'h00; man_d = 8'h00; bist_start = 1'b0; inj_mask = 8'h00;
    model_q = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bist_busy, 0);
    check_eq("rst_done", bist_done, 0);
    check_eq("rst_pass", bist_pass, 0);
    check_eq("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", bist_busy, 0);

    set_man(8'hFF, 8'hFF, 8'hA5, 1'b0);
    check_eq("man_pos_open", q, 8'hA5);
    set_man(8'hFF, 8'h00, 8'h00, 1'b0);
    check_eq("man_pos_hold", q, 8'hA5);
    set_man(8'h00, 8'h00, 8'h3C, 1'b0);
    check_eq("man_neg_open", q, 8'h3C);
    set_man(8'h00, 8'hFF, 8'hFF, 1'b0);
    check_eq("man_neg_hold", q, 8'h3C);

    for (int i = 0; i < 24; i++) begin
      p = 8'($urandom); e = 8'($urandom); d = 8'($urandom);
      r = ($urandom_range(0, 3) == 0);
      set_man(p, e, d, r);
      check_eq("man_rand", q, model_q);
    end
    set_man(pol, man_en, man_d, 1'b0);
    check_eq("man_rst_release", q, model_q);

    for (int run = 0; run < 5; run++) begin
      p = (run == 0) ? 8'h0F : 8'($urandom);
`ifdef LATCH_BIST_INJECT_EN
      inj_mask = (run == 1) ? 8'h01 : ((run % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
`endif
      set_man(p, ~p, 8'($urandom), 1'b0);
      run_bist(1'b0, busy_cyc, done_cyc, done_cnt, q_bad);
      check_eq("bist_busy_cycles", busy_cyc, RUN_CYC + 1);
      check_eq("bist_done_cycle", done_cyc, RUN_CYC + 1);
      check_eq("bist_done_count", done_cnt, 1);
      check_eq("bist_q_trace", q_bad, 0);
      check_eq("bist_err", err_cnt, exp_errs(inj_mask, CNT_W));
      check_eq("bist_pass", bist_pass, (exp_errs(inj_mask, CNT_W) == 0));
      check_eq("bist_done_after", bist_done, 0);
      check_eq("bist_q_final", q, model_pat(N_PAT - 1));
`ifdef LATCH_BIST_INJECT_EN
      check_eq("bist_err_sat", err_sat, exp_errs(inj_mask, 4));
`endif
      model_q = model_pat(N_PAT - 1);
    end

    // Held start: exactly one idle cycle between runs, then a full second run.
    inj_mask = 8'h00;
    set_man(8'h5A, 8'hA5, 8'h00, 1'b0);
    run_bist(1'b1, busy_cyc, done_cyc, done_cnt, q_bad);
    check_eq("hold_busy_cycles", busy_cyc, RUN_CYC + 1);
    check_eq("hold_q_trace", q_bad, 0);
    check_eq("hold_gap_idle", bist_busy, 0);
    @(negedge clk);
    check_eq("hold_restart", bist_busy, 1);
    bist_start = 1'b0;
    cnt = 0;
    done_seen = 0;
    while (bist_busy && cnt < 300) begin
      cnt++;
      if (bist_done) done_seen++;
      @(negedge clk);
    end
    check_eq("hold_run2_cycles", cnt, RUN_CYC + 1);
    check_eq("hold_run2_done", done_seen, 1);
    check_eq("hold_run2_pass", bist_pass, 1);

    // Reset during a run aborts cleanly with no completion pulse.
`ifdef LATCH_BIST_INJECT_EN
    inj_mask = 8'h01;
`endif
    set_man(8'hC3, 8'h3C, 8'h00, 1'b0);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    for (int c = 1; c < 40; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", bist_busy, 0);
    check_eq("abort_done", bist_done, 0);
    check_eq("abort_err", err_cnt, 0);
    check_eq("abort_pass", bist_pass, 0);
    check_eq("abort_q", q, model_pat(39 / PAT_CYC));
    done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (bist_done || bist_busy) done_seen++;
      @(negedge clk);
    end
    check_eq("abort_quiet", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
